// File: rtl/cmd_pkg.sv
// Shared command types and constants for the calculator command front-end.
// cmd_t is the default-width entry layout; the front-end builds the same layout at its own widths.
package cmd_pkg;

  localparam int SEL_W      = 4;
  localparam int DIN_W      = 32;
  localparam int CMD_ADDR_W = 8;
  localparam int CMD_OPND_W = 8;

  typedef struct packed {
    logic                  rw;
    logic [SEL_W-1:0]      sel;
    logic [DIN_W-1:0]      din;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_OPND_W-1:0] a;
    logic [CMD_OPND_W-1:0] b;
  } cmd_t;

  // The divider must never be programmed to zero, so zero is promoted to one.
  function automatic logic [DIN_W-1:0] clamp_div(input logic [DIN_W-1:0] v);
    return (v == '0) ? DIN_W'(1) : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a registered occupancy count.
// Full/empty come from the registered level, so a push while full is refused even alongside a pop.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (PW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is deliberately left unreset; stale entries are never visible past the level count.
  always_ff @(posedge clk) begin
    if (reset_n && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cmd_queue_frontend.sv
// Command front-end: key-gated acceptance, local divider configuration, and a buffered
// valid/ready command stream toward the decoder with sticky overflow reporting.
module cmd_queue_frontend
  import cmd_pkg::*;
#(
  parameter int INBITS    = 8,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   InputKey,
  input  logic                   ValidCmd,
  input  logic                   RW,
  input  logic                   ConfigDiv,
  input  logic [SEL_W-1:0]       Sel,
  input  logic [DIN_W-1:0]       Din,
  input  logic [WIDTH-1:0]       Addr,
  input  logic [INBITS-1:0]      inA,
  input  logic [INBITS-1:0]      inB,
  output logic                   CmdReady,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic                   OutRW,
  output logic [SEL_W-1:0]       OutSel,
  output logic [DIN_W-1:0]       OutDin,
  output logic [WIDTH-1:0]       OutAddr,
  output logic [INBITS-1:0]      OutA,
  output logic [INBITS-1:0]      OutB,
  output logic [$clog2(DEPTH):0] Level,
  output logic [DIV_W-1:0]       DivValue,
  output logic                   DropErr
);

  typedef struct packed {
    logic              rw;
    logic [SEL_W-1:0]  sel;
    logic [DIN_W-1:0]  din;
    logic [WIDTH-1:0]  addr;
    logic [INBITS-1:0] a;
    logic [INBITS-1:0] b;
  } entry_t;

  entry_t     in_entry;
  entry_t     head;
  entry_t     shown;
  logic       accept;
  logic       cfg_take;
  logic       queue_req;
  logic       pop;
  logic       full;
  logic       empty;
  logic [DIV_W-1:0] div_next;

  assign accept    = ValidCmd & InputKey;
  assign cfg_take  = accept & ConfigDiv;
  assign queue_req = accept & ~ConfigDiv;
  assign pop       = OutValid & OutReady;
  assign in_entry  = '{rw: RW, sel: Sel, din: Din, addr: Addr, a: inA, b: inB};
  assign div_next  = DIV_W'(clamp_div(DIN_W'(Din[DIV_W-1:0])));

  sync_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .reset_n (Reset),
    .push    (queue_req),
    .pop     (pop),
    .din     (in_entry),
    .dout    (head),
    .level   (Level),
    .full    (full),
    .empty   (empty)
  );

  assign CmdReady = ~full;
  assign OutValid = ~empty;
  // Unreset storage would otherwise leak onto the outputs while the queue is empty.
  assign shown    = OutValid ? head : '0;
  assign OutRW    = shown.rw;
  assign OutSel   = shown.sel;
  assign OutDin   = shown.din;
  assign OutAddr  = shown.addr;
  assign OutA     = shown.a;
  assign OutB     = shown.b;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      DivValue <= DIV_W'(DIV_RESET);
      DropErr  <= 1'b0;
    end else begin
      if (cfg_take)          DivValue <= div_next;
      if (queue_req && full) DropErr  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_queue_frontend.sv
// Directed self-checking bench for cmd_queue_frontend at default parameters (DEPTH=4, DIV_RESET=1).
module tb_cmd_queue_frontend;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        InputKey = 1'b0;
  logic        ValidCmd = 1'b0;
  logic        RW = 1'b0;
  logic        ConfigDiv = 1'b0;
  logic [3:0]  Sel = '0;
  logic [31:0] Din = '0;
  logic [7:0]  Addr = '0;
  logic [7:0]  inA = '0;
  logic [7:0]  inB = '0;
  logic        OutReady = 1'b0;
  logic        CmdReady, OutValid, OutRW, DropErr;
  logic [3:0]  OutSel;
  logic [31:0] OutDin;
  logic [7:0]  OutAddr, OutA, OutB, DivValue;
  logic [2:0]  Level;

  int assertions = 0;
  int failures   = 0;

  cmd_queue_frontend dut (
    .Clk(Clk), .Reset(Reset), .InputKey(InputKey), .ValidCmd(ValidCmd), .RW(RW),
    .ConfigDiv(ConfigDiv), .Sel(Sel), .Din(Din), .Addr(Addr), .inA(inA), .inB(inB),
    .CmdReady(CmdReady), .OutValid(OutValid), .OutReady(OutReady), .OutRW(OutRW),
    .OutSel(OutSel), .OutDin(OutDin), .OutAddr(OutAddr), .OutA(OutA), .OutB(OutB),
    .Level(Level), .DivValue(DivValue), .DropErr(DropErr)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Every field of a queued command is derived from its address so the head can be fully predicted.
  task automatic drive_cmd(input logic v, input logic cfg, input logic [7:0] a, input logic [31:0] d);
    ValidCmd  = v;
    ConfigDiv = cfg;
    Addr      = a;
    Din       = d;
    RW        = a[0];
    Sel       = a[3:0];
    inA       = ~a;
    inB       = a + 8'd1;
  endtask

  task automatic do_reset();
    drive_cmd(1'b0, 1'b0, 8'h00, 32'h0);
    OutReady = 1'b0;
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    assertions++; if (Level !== 3'd0) begin failures++; $display("[TB] FAIL reset_level got %0d expected 0", Level); end
    assertions++; if (OutValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_outvalid got %b expected 0", OutValid); end
    assertions++; if (CmdReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_cmdready got %b expected 1", CmdReady); end
    assertions++; if (DivValue !== 8'd1) begin failures++; $display("[TB] FAIL reset_div got %0d expected 1", DivValue); end
    assertions++; if (DropErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_droperr got %b expected 0", DropErr); end
    assertions++; if ({OutRW, OutSel, OutDin, OutAddr, OutA, OutB} !== 61'd0) begin failures++; $display("[TB] FAIL reset_outfields got %h expected 0", {OutRW, OutSel, OutDin, OutAddr, OutA, OutB}); end
  endtask

  task automatic test_basic_order();
    logic [7:0] exp_a;
    InputKey = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_cmd(1'b1, 1'b0, 8'(i), 32'hD000_0000 | 32'(i));
      tick();
    end
    drive_cmd(1'b0, 1'b0, 8'h00, 32'h0);
    assertions++; if (Level !== 3'd3) begin failures++; $display("[TB] FAIL basic_level got %0d expected 3", Level); end
    assertions++; if (OutValid !== 1'b1) begin failures++; $display("[TB] FAIL basic_outvalid got %b expected 1", OutValid); end
    OutReady = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_a = 8'(i);
      assertions++; if (OutAddr !== exp_a) begin failures++; $display("[TB] FAIL basic_head_addr got %h expected %h", OutAddr, exp_a); end
      assertions++; if ({OutRW, OutSel, OutDin, OutA, OutB} !== {exp_a[0], exp_a[3:0], 32'hD000_0000 | 32'(i), ~exp_a, exp_a + 8'd1}) begin
        failures++; $display("[TB] FAIL basic_head_fields got %h for addr %h", {OutRW, OutSel, OutDin, OutA, OutB}, exp_a);
      end
      tick();
    end
    OutReady = 1'b0;
    assertions++; if (OutValid !== 1'b0) begin failures++; $display("[TB] FAIL basic_drained_valid got %b expected 0", OutValid); end
    assertions++; if (OutAddr !== 8'h00) begin failures++; $display("[TB] FAIL basic_drained_addr got %h expected 00", OutAddr); end
  endtask

  task automatic test_key_gating();
    InputKey = 1'b0;
    drive_cmd(1'b1, 1'b0, 8'h30, 32'h30);
    tick();
    drive_cmd(1'b1, 1'b1, 8'h00, 32'h7);
    tick();
    drive_cmd(1'b0, 1'b0, 8'h00, 32'h0);
    InputKey = 1'b1;
    assertions++; if (Level !== 3'd0) begin failures++; $display("[TB] FAIL key_level got %0d expected 0", Level); end
    assertions++; if (DivValue !== 8'd1) begin failures++; $display("[TB] FAIL key_div got %0d expected 1", DivValue); end
    assertions++; if (DropErr !== 1'b0) begin failures++; $display("[TB] FAIL key_droperr got %b expected 0", DropErr); end
  endtask

  task automatic test_config();
    drive_cmd(1'b1, 1'b1, 8'h00, 32'h0000_0005);
    tick();
    assertions++; if (DivValue !== 8'd5) begin failures++; $display("[TB] FAIL cfg_div5 got %0d expected 5", DivValue); end
    assertions++; if (Level !== 3'd4) begin failures++; $display("[TB] FAIL cfg_level got %0d expected 4", Level); end
    assertions++; if (DropErr !== 1'b1) begin failures++; $display("[TB] FAIL cfg_droperr got %b expected 1", DropErr); end
    drive_cmd(1'b1, 1'b1, 8'h00, 32'h0);
    tick();
    assertions++; if (DivValue !== 8'd1) begin failures++; $display("[TB] FAIL cfg_clamp got %0d expected 1", DivValue); end
    drive_cmd(1'b1, 1'b1, 8'h00, 32'h0000_01FF);
    tick();
    assertions++; if (DivValue !== 8'hFF) begin failures++; $display("[TB] FAIL cfg_trunc got %h expected ff", DivValue); end
    drive_cmd(1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic test_full_drop();
    logic [7:0] order [4];
    order = '{8'h11, 8'h12, 8'h13, 8'h16};
    do_reset();
    InputKey = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b1, 1'b0, 8'h10 + 8'(i), 32'h0);
      tick();
    end
    assertions++; if (Level !== 3'd4) begin failures++; $display("[TB] FAIL full_level got %0d expected 4", Level); end
    assertions++; if (CmdReady !== 1'b0) begin failures++; $display("[TB] FAIL full_cmdready got %b expected 0", CmdReady); end
    assertions++; if (DropErr !== 1'b0) begin failures++; $display("[TB] FAIL full_droperr_pre got %b expected 0", DropErr); end
    drive_cmd(1'b1, 1'b0, 8'h14, 32'h0);
    tick();
    assertions++; if (Level !== 3'd4) begin failures++; $display("[TB] FAIL drop_level got %0d expected 4", Level); end
    assertions++; if (DropErr !== 1'b1) begin failures++; $display("[TB] FAIL drop_droperr got %b expected 1", DropErr); end
    drive_cmd(1'b1, 1'b0, 8'h15, 32'h0);
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    assertions++; if (Level !== 3'd3) begin failures++; $display("[TB] FAIL fullpoppush_level got %0d expected 3", Level); end
    assertions++; if (CmdReady !== 1'b1) begin failures++; $display("[TB] FAIL fullpoppush_ready got %b expected 1", CmdReady); end
    drive_cmd(1'b1, 1'b0, 8'h16, 32'h0);
    tick();
    test_config();
    OutReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      assertions++; if (OutAddr !== order[k]) begin failures++; $display("[TB] FAIL full_order got %h expected %h", OutAddr, order[k]); end
      tick();
    end
    OutReady = 1'b0;
    assertions++; if (OutValid !== 1'b0) begin failures++; $display("[TB] FAIL full_drained got %b expected 0", OutValid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_a;
    do_reset();
    InputKey = 1'b1;
    drive_cmd(1'b1, 1'b0, 8'h20, 32'h0);
    tick();
    drive_cmd(1'b1, 1'b0, 8'h21, 32'h0);
    tick();
    OutReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_cmd(1'b1, 1'b0, 8'h22 + 8'(i), 32'h0);
      tick();
      exp_a = 8'h21 + 8'(i);
      assertions++; if (Level !== 3'd2) begin failures++; $display("[TB] FAIL b2b_level got %0d expected 2", Level); end
      assertions++; if (OutAddr !== exp_a) begin failures++; $display("[TB] FAIL b2b_head got %h expected %h", OutAddr, exp_a); end
    end
    drive_cmd(1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    assertions++; if (OutAddr !== 8'h2B) begin failures++; $display("[TB] FAIL b2b_tail got %h expected 2b", OutAddr); end
    tick();
    OutReady = 1'b0;
    assertions++; if (Level !== 3'd0) begin failures++; $display("[TB] FAIL b2b_empty got %0d expected 0", Level); end
  endtask

  task automatic test_mid_reset();
    drive_cmd(1'b1, 1'b1, 8'h00, 32'h9);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1'b1, 1'b0, 8'h40 + 8'(i), 32'h0);
      tick();
    end
    drive_cmd(1'b1, 1'b0, 8'h4F, 32'h0);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    drive_cmd(1'b0, 1'b0, 8'h00, 32'h0);
    assertions++; if (Level !== 3'd0) begin failures++; $display("[TB] FAIL midrst_level got %0d expected 0", Level); end
    assertions++; if (OutValid !== 1'b0 || OutAddr !== 8'h00 || OutDin !== 32'h0) begin failures++; $display("[TB] FAIL midrst_out got valid=%b addr=%h expected 0/00", OutValid, OutAddr); end
    assertions++; if (DivValue !== 8'd1) begin failures++; $display("[TB] FAIL midrst_div got %0d expected 1", DivValue); end
    assertions++; if (CmdReady !== 1'b1 || DropErr !== 1'b0) begin failures++; $display("[TB] FAIL midrst_flags got ready=%b drop=%b expected 1/0", CmdReady, DropErr); end
    tick();
    drive_cmd(1'b1, 1'b0, 8'h41, 32'h0);
    tick();
    drive_cmd(1'b0, 1'b0, 8'h00, 32'h0);
    assertions++; if (Level !== 3'd1 || OutAddr !== 8'h41) begin failures++; $display("[TB] FAIL postrst_push got level=%0d addr=%h expected 1/41", Level, OutAddr); end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_key_gating();
    test_full_drop();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
